lpif_txrx_x4_f2_stb_mrk_sched: RTL
==================================

// Module: lpif_txrx_x4_f2_stb_mrk_sched
// PURPOSE
//  TX-side scheduler for the x4 full-rate Gen2 master concat datapath. Brings the link up and
//  generates the persistent strobe and marker userbits that the concat block inserts into the
//  PHY word (strobe at bit 1, marker at bit 77).
//  Gates upstream pop (tx_ready) until the far side has seen ALIGN_STROBES strobes.
//  Sits between link-layer control and the concat block, in the clk_wr domain.
// PARAMETERS
//  STB_PERIOD     16  cycles between strobes; >=2; integer multiple of MRK_PERIOD (elab $error otherwise)
//  MRK_PERIOD     2   beats per marker frame (f2 => 2)
//  ALIGN_STROBES  4   strobes sent in ALIGN before RUN; >=1
// PORTS
//  clk_wr          in   1   write clock
//  rst_wr          in   1   asynchronous, active-high reset
//  tx_en           in   1   software enable for link bring-up
//  tx_online       in   1   adapter TX online
//  m_gen2_mode     in   1   1=Gen2, 0=Gen1; quasi-static, registered internally
//  tx_stb_userbit  out  1   strobe to concat
//  tx_mrk_userbit  out  1   marker to concat, [0:0]
//  tx_ready        out  1   upstream may pop/send data
//  align_done      out  1   sticky until IDLE/WAIT_ON: ALIGN completed
//  state_o         out  2   FSM state: IDLE=0, WAIT_ON=1, ALIGN=2, RUN=3
// BEHAVIOUR
//  - Reset: state=IDLE; stb_cnt=0, mrk_cnt=0, aln_cnt=0, gen2_q=0. Every output is 0.
//  - All outputs decode flops only; there is no comb path from any input to any output.
//  - Transition priority, evaluated every cycle:
//      tx_en=0                        -> IDLE
//      else tx_online=0 in ALIGN/RUN  -> WAIT_ON
//      else normal transitions:
//        IDLE   -> WAIT_ON.
//        WAIT_ON: tx_online=1 -> ALIGN; stb_cnt, mrk_cnt, aln_cnt cleared on entry.
//        ALIGN  -> RUN on the edge ending the cycle that carries strobe number ALIGN_STROBES.
//        RUN    holds.
//  - stb_cnt 0..STB_PERIOD-1: increments in ALIGN/RUN, wraps to 0, held at 0 otherwise.
//  - mrk_cnt 0..MRK_PERIOD-1: same rules as stb_cnt.
//  - tx_stb_userbit = (state in ALIGN/RUN) && stb_cnt==0. Strobe always falls on beat 0 of a marker frame.
//  - tx_mrk_userbit = (state in ALIGN/RUN) && gen2_q && mrk_cnt==MRK_PERIOD-1. Gen1: marker held 0, strobe unchanged.
//  - aln_cnt ($clog2(ALIGN_STROBES+1) bits) counts strobes in ALIGN only.
//  - tx_ready = state==RUN.
//  - align_done: set on ALIGN->RUN; cleared in IDLE and WAIT_ON.
//  - Latency: tx_online sampled 1 at edge T -> ALIGN, first strobe in cycle T+1.
//    Defaults: strobes at T+1, T+17, T+33, T+49; RUN and tx_ready from T+50; next strobe T+65.
//  - Mid-operation drop (tx_online or tx_en falls): tx_ready, strobe and marker are 0 the cycle after.
//    Counters clear; a new bring-up restarts ALIGN from scratch.
//  - tx_online and tx_en both rising in one cycle: IDLE->WAIT_ON->ALIGN, 2 cycles minimum.
//  - Reset asserted mid-operation: immediate (asynchronous) return to reset values.
// CONFIGURATION
//  LPIF_TXRX_STB_DBG_EN defined:
//    adds out dbg_stb_cnt[15:0], a count of strobes emitted in RUN.
//    Saturates at 16'hFFFF; cleared in IDLE and on reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Defaults, tx_en=1, tx_online=1 at T:
//    -> strobes T+1,+17,+33,+49; tx_ready=1 at T+50; state_o=3.
//  2 RUN, Gen2, 40 cycles:
//    -> marker every 2nd cycle (odd mrk_cnt); strobe every 16 cycles, always coincident with mrk_cnt=0.
//  3 tx_online->0 during ALIGN after 2 strobes, re-raised 5 cycles later:
//    -> WAIT_ON; full 4 strobes needed again before tx_ready.
//  4 tx_en->0 in RUN -> next cycle state_o=0; tx_ready, strobe, marker=0; align_done=0.
//  5 m_gen2_mode=0 bring-up -> marker constant 0; strobe timing as in test 1.
//  6 rst_wr pulse in RUN mid-period -> all outputs 0 asynchronously; after release stays IDLE until tx_en.
//    With LPIF_TXRX_STB_DBG_EN: dbg_stb_cnt=0 after the reset.

Source files
------------

// File: rtl/lpif_txrx_x4_f2_stb_mrk_sched.sv
// TX-side strobe/marker scheduler and link bring-up FSM for the x4 full-rate Gen2 concat datapath.
// Optional macro LPIF_TXRX_STB_DBG_EN adds o_dbg_stb_cnt, a saturating count of strobes sent in RUN.
module lpif_txrx_x4_f2_stb_mrk_sched #(
    parameter int STB_PERIOD    = 16,
    parameter int MRK_PERIOD    = 2,
    parameter int ALIGN_STROBES = 4
) (
    input  logic        i_clk_wr,
    input  logic        i_rst_wr,
    input  logic        i_tx_en,
    input  logic        i_tx_online,
    input  logic        i_m_gen2_mode,
    output logic        o_tx_stb_userbit,
    output logic        o_tx_mrk_userbit,
    output logic        o_tx_ready,
    output logic        o_align_done,
    output logic [1:0]  o_state
`ifdef LPIF_TXRX_STB_DBG_EN
    ,
    output logic [15:0] o_dbg_stb_cnt
`endif
);

    localparam int SW = $clog2(STB_PERIOD);
    localparam int MW = (MRK_PERIOD > 1) ? $clog2(MRK_PERIOD) : 1;
    localparam int AW = $clog2(ALIGN_STROBES + 1);

    localparam logic [SW-1:0] STB_LAST = SW'(STB_PERIOD - 1);
    localparam logic [MW-1:0] MRK_LAST = MW'(MRK_PERIOD - 1);
    localparam logic [AW-1:0] ALN_LAST = AW'(ALIGN_STROBES - 1);

    if ((STB_PERIOD < 2) || (MRK_PERIOD < 1) || (ALIGN_STROBES < 1) ||
        ((STB_PERIOD % MRK_PERIOD) != 0)) begin : g_bad_params
        $error("lpif_txrx_x4_f2_stb_mrk_sched: illegal STB_PERIOD/MRK_PERIOD/ALIGN_STROBES");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_ON = 2'd1,
        ST_ALIGN   = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_stb_cnt;
    logic [MW-1:0]   r_mrk_cnt;
    logic [AW-1:0]   r_aln_cnt;
    logic            r_gen2_q;
    logic            r_align_done;

    state_t          w_next;
    logic            w_active;
    logic            w_next_active;
    logic            w_stb;

    assign w_active      = (r_state == ST_ALIGN) || (r_state == ST_RUN);
    assign w_next_active = (w_next == ST_ALIGN) || (w_next == ST_RUN);
    assign w_stb         = w_active && (r_stb_cnt == '0);

    // Enable loss dominates, then loss of the adapter while the link is up.
    always_comb begin
        w_next = r_state;
        if (!i_tx_en) begin
            w_next = ST_IDLE;
        end else if (!i_tx_online && w_active) begin
            w_next = ST_WAIT_ON;
        end else begin
            case (r_state)
                ST_IDLE:    w_next = ST_WAIT_ON;
                ST_WAIT_ON: if (i_tx_online) w_next = ST_ALIGN;
                ST_ALIGN:   if (w_stb && (r_aln_cnt == ALN_LAST)) w_next = ST_RUN;
                default:    w_next = ST_RUN;
            endcase
        end
    end

    // Counters only run while staying inside ALIGN/RUN, so every fresh bring-up starts from zero.
    always_ff @(posedge i_clk_wr or posedge i_rst_wr) begin
        if (i_rst_wr) begin
            r_state      <= ST_IDLE;
            r_stb_cnt    <= '0;
            r_mrk_cnt    <= '0;
            r_aln_cnt    <= '0;
            r_gen2_q     <= 1'b0;
            r_align_done <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_gen2_q <= i_m_gen2_mode;
            if (w_active && w_next_active) begin
                r_stb_cnt <= (r_stb_cnt == STB_LAST) ? '0 : r_stb_cnt + SW'(1);
                r_mrk_cnt <= (r_mrk_cnt == MRK_LAST) ? '0 : r_mrk_cnt + MW'(1);
                if ((r_state == ST_ALIGN) && w_stb) begin
                    r_aln_cnt <= r_aln_cnt + AW'(1);
                end
            end else begin
                r_stb_cnt <= '0;
                r_mrk_cnt <= '0;
                r_aln_cnt <= '0;
            end
            if ((w_next == ST_IDLE) || (w_next == ST_WAIT_ON)) begin
                r_align_done <= 1'b0;
            end else if ((r_state == ST_ALIGN) && (w_next == ST_RUN)) begin
                r_align_done <= 1'b1;
            end
        end
    end

`ifdef LPIF_TXRX_STB_DBG_EN
    logic [15:0] r_dbg_stb_cnt;

    always_ff @(posedge i_clk_wr or posedge i_rst_wr) begin
        if (i_rst_wr) begin
            r_dbg_stb_cnt <= '0;
        end else if ((r_state == ST_IDLE) || (w_next == ST_IDLE)) begin
            r_dbg_stb_cnt <= '0;
        end else if ((r_state == ST_RUN) && w_stb && (r_dbg_stb_cnt != 16'hFFFF)) begin
            r_dbg_stb_cnt <= r_dbg_stb_cnt + 16'd1;
        end
    end

    assign o_dbg_stb_cnt = r_dbg_stb_cnt;
`endif

    assign o_tx_stb_userbit = w_stb;
    assign o_tx_mrk_userbit = w_active && r_gen2_q && (r_mrk_cnt == MRK_LAST);
    assign o_tx_ready       = (r_state == ST_RUN);
    assign o_align_done     = r_align_done;
    assign o_state          = r_state;

endmodule
